key_mode_sel: RTL and testbench

Debounced push-button front end that turns the two board keys into a test-pattern mode selection. It runs in the `led_clk` (27 MHz) domain and sits directly upstream of the pixel-domain mode register that drives the test pattern generator's `I_mode`. It supports short-press mode stepping, a long two-key press that toggles automatic (raster-banded) mode, a toggle-based handshake for the clock-domain crossing, and an optional LED status display.

---
 rtl/key_mode_sel.sv | 211 +++++++++++++++++++++
 tb/tb_key_mode_sel.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/key_mode_sel.sv
// Two-key debounced front end producing test-pattern mode, auto-mode flag and a toggle/strobe CDC handshake.
// Optional LED status display is enabled by defining KEY_MODE_SEL_LED_EN; otherwise leds are tied off.
module key_mode_sel #(
  parameter int DEB_CYCLES  = 270000,
  parameter int LONG_CYCLES = 27000000,
  parameter int NUM_MODES   = 4
) (
  input  logic       led_clk,
  input  logic       hdmi4_rst_n,
  input  logic       key_a,
  input  logic       key_b,
  output logic [2:0] mode,
  output logic       auto_en,
  output logic       mode_tog,
  output logic       mode_stb,
  output logic [5:0] leds
);

  localparam int DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_TC   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_TC  = LONG_W'(LONG_CYCLES - 1);
  localparam logic [2:0]        MODE_MAX = 3'(NUM_MODES - 1);

  if (NUM_MODES < 2 || NUM_MODES > 8) begin : g_bad_num_modes
    $error("key_mode_sel: NUM_MODES must be in 2..8");
  end
  if (DEB_CYCLES < 1 || LONG_CYCLES < 2) begin : g_bad_cycles
    $error("key_mode_sel: DEB_CYCLES must be >= 1 and LONG_CYCLES >= 2");
  end

  // IDLE: no key down | ONE: one key down | BOTH: combo timing | WAIT_REL: wait for all keys up
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ONE      = 2'd1,
    S_BOTH     = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  logic [1:0]        r_sync1;
  logic [1:0]        r_sync2;
  logic [1:0]        r_deb;
  logic [DEB_W-1:0]  r_deb_cnt [2];
  logic [LONG_W-1:0] r_combo_cnt;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sel_b;
  logic              w_sel_b_nxt;

  logic [2:0]        r_mode;
  logic              r_auto_en;
  logic              r_mode_tog;
  logic              r_mode_stb;

  logic              w_both;
  logic              w_any;
  logic              w_held;
  logic              w_ev_next;
  logic              w_ev_prev;
  logic              w_ev_combo;
  logic              w_ev_any;
  logic [2:0]        w_mode_inc;
  logic [2:0]        w_mode_dec;

  // Bit 0 is key A, bit 1 is key B throughout.
  always_ff @(posedge led_clk or negedge hdmi4_rst_n) begin
    if (!hdmi4_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int k = 0; k < 2; k++) begin
        r_deb_cnt[k] <= '0;
      end
    end else begin
      r_sync1 <= {key_b, key_a};
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_deb_cnt[k] <= '0;
        end else if (r_deb_cnt[k] == DEB_TC) begin
          r_deb[k]     <= r_sync2[k];
          r_deb_cnt[k] <= '0;
        end else begin
          r_deb_cnt[k] <= r_deb_cnt[k] + DEB_W'(1);
        end
      end
    end
  end

  assign w_both = r_deb[0] & r_deb[1];
  assign w_any  = r_deb[0] | r_deb[1];
  assign w_held = r_sel_b ? r_deb[1] : r_deb[0];

  always_comb begin
    w_state_nxt = r_state;
    w_sel_b_nxt = r_sel_b;
    w_ev_next   = 1'b0;
    w_ev_prev   = 1'b0;
    w_ev_combo  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_both) begin
          w_state_nxt = S_BOTH;
        end else if (w_any) begin
          w_state_nxt = S_ONE;
          w_sel_b_nxt = r_deb[1];
        end
      end
      S_ONE: begin
        if (w_both) begin
          w_state_nxt = S_BOTH;
        end else if (!w_held) begin
          w_state_nxt = S_IDLE;
          w_ev_next   = ~r_sel_b;
          w_ev_prev   = r_sel_b;
        end
      end
      S_BOTH: begin
        // Terminal count wins over a release in the same cycle.
        if (r_combo_cnt == LONG_TC) begin
          w_state_nxt = S_WAIT_REL;
          w_ev_combo  = 1'b1;
        end else if (!w_both) begin
          w_state_nxt = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (!w_any) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge led_clk or negedge hdmi4_rst_n) begin
    if (!hdmi4_rst_n) begin
      r_state <= S_IDLE;
      r_sel_b <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel_b <= w_sel_b_nxt;
    end
  end

  always_ff @(posedge led_clk or negedge hdmi4_rst_n) begin
    if (!hdmi4_rst_n) begin
      r_combo_cnt <= '0;
    end else if (r_state != S_BOTH) begin
      r_combo_cnt <= '0;
    end else if (r_combo_cnt != LONG_TC) begin
      r_combo_cnt <= r_combo_cnt + LONG_W'(1);
    end
  end

  assign w_ev_any   = w_ev_next | w_ev_prev | w_ev_combo;
  assign w_mode_inc = (r_mode == MODE_MAX) ? 3'd0 : r_mode + 3'd1;
  assign w_mode_dec = (r_mode == 3'd0) ? MODE_MAX : r_mode - 3'd1;

  always_ff @(posedge led_clk or negedge hdmi4_rst_n) begin
    if (!hdmi4_rst_n) begin
      r_mode     <= 3'd0;
      r_auto_en  <= 1'b1;
      r_mode_tog <= 1'b0;
      r_mode_stb <= 1'b0;
    end else begin
      r_mode_stb <= w_ev_any;
      if (w_ev_any) begin
        r_mode_tog <= ~r_mode_tog;
      end
      if (w_ev_next) begin
        r_mode    <= w_mode_inc;
        r_auto_en <= 1'b0;
      end else if (w_ev_prev) begin
        r_mode    <= w_mode_dec;
        r_auto_en <= 1'b0;
      end else if (w_ev_combo) begin
        r_auto_en <= ~r_auto_en;
      end
    end
  end

  assign mode     = r_mode;
  assign auto_en  = r_auto_en;
  assign mode_tog = r_mode_tog;
  assign mode_stb = r_mode_stb;

`ifdef KEY_MODE_SEL_LED_EN
  logic [5:0] r_leds;
  logic [3:0] w_onehot;

  // Modes above 3 shift out of the 4-bit window, leaving those LEDs dark.
  assign w_onehot = 4'b0001 << r_mode;

  always_ff @(posedge led_clk or negedge hdmi4_rst_n) begin
    if (!hdmi4_rst_n) begin
      r_leds <= 6'b101110;
    end else begin
      r_leds <= {~w_any, ~r_auto_en, ~w_onehot};
    end
  end

  assign leds = r_leds;
`else
  assign leds = 6'b111111;
`endif

endmodule

// File: tb/tb_key_mode_sel.sv
// Directed-vector bench for key_mode_sel with DEB_CYCLES=4, LONG_CYCLES=32, NUM_MODES=4.
module tb_key_mode_sel;

  logic       led_clk = 1'b0;
  logic       hdmi4_rst_n = 1'b0;
  logic       key_a = 1'b0;
  logic       key_b = 1'b0;
  logic [2:0] mode;
  logic       auto_en;
  logic       mode_tog;
  logic       mode_stb;
  logic [5:0] leds;

  int checks   = 0;
  int failures = 0;
  int stb_cnt  = 0;

`ifdef KEY_MODE_SEL_LED_EN
  localparam logic [5:0] LEDS_RST = 6'b101110;
  localparam logic [5:0] LEDS_M1  = 6'b111101;
  localparam logic [5:0] LEDS_M3A = 6'b100111;
`else
  localparam logic [5:0] LEDS_RST = 6'b111111;
  localparam logic [5:0] LEDS_M1  = 6'b111111;
  localparam logic [5:0] LEDS_M3A = 6'b111111;
`endif

  key_mode_sel #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(32),
    .NUM_MODES  (4)
  ) dut (
    .led_clk    (led_clk),
    .hdmi4_rst_n(hdmi4_rst_n),
    .key_a      (key_a),
    .key_b      (key_b),
    .mode       (mode),
    .auto_en    (auto_en),
    .mode_tog   (mode_tog),
    .mode_stb   (mode_stb),
    .leds       (leds)
  );

  always #5 led_clk = ~led_clk;

  always @(negedge led_clk) begin
    if (mode_stb === 1'b1) stb_cnt++;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge led_clk);
  endtask

  task automatic test_reset;
    hdmi4_rst_n = 1'b0;
    key_a = 1'b0;
    key_b = 1'b0;
    wait_neg(3);
    checks++; if (mode !== 3'd0) begin failures++; $display("FAIL rst_mode: got %0d want 0", mode); end
    checks++; if (auto_en !== 1'b1) begin failures++; $display("FAIL rst_auto_en: got %b want 1", auto_en); end
    checks++; if (mode_tog !== 1'b0) begin failures++; $display("FAIL rst_mode_tog: got %b want 0", mode_tog); end
    checks++; if (mode_stb !== 1'b0) begin failures++; $display("FAIL rst_mode_stb: got %b want 0", mode_stb); end
    checks++; if (leds !== LEDS_RST) begin failures++; $display("FAIL rst_leds: got %b want %b", leds, LEDS_RST); end
    hdmi4_rst_n = 1'b1;
    wait_neg(3);
    checks++; if (mode !== 3'd0 || auto_en !== 1'b1) begin failures++; $display("FAIL post_rst_idle: got mode=%0d auto=%b want mode=0 auto=1", mode, auto_en); end
    checks++; if (leds !== LEDS_RST) begin failures++; $display("FAIL post_rst_leds: got %b want %b", leds, LEDS_RST); end
  endtask

  task automatic test_step_fwd;
    int base;
    logic [2:0] exp_mode [4];
    exp_mode[0] = 3'd1;
    exp_mode[1] = 3'd2;
    exp_mode[2] = 3'd3;
    exp_mode[3] = 3'd0;
    base = stb_cnt;
    for (int p = 0; p < 4; p++) begin
      key_a = 1'b1;
      wait_neg(10);
      key_a = 1'b0;
      if (p == 0) begin
        wait_neg(6);
        checks++; if (mode !== 3'd0 || auto_en !== 1'b1) begin failures++; $display("FAIL fwd_latency_early: got mode=%0d auto=%b want mode=0 auto=1", mode, auto_en); end
        wait_neg(1);
        checks++; if (mode !== 3'd1) begin failures++; $display("FAIL fwd_latency_mode: got %0d want 1", mode); end
        checks++; if (mode_stb !== 1'b1) begin failures++; $display("FAIL fwd_stb_high: got %b want 1", mode_stb); end
        wait_neg(1);
        checks++; if (mode_stb !== 1'b0) begin failures++; $display("FAIL fwd_stb_one_cycle: got %b want 0", mode_stb); end
        wait_neg(10);
        checks++; if (leds !== LEDS_M1) begin failures++; $display("FAIL fwd_leds_m1: got %b want %b", leds, LEDS_M1); end
      end else begin
        wait_neg(18);
      end
      checks++; if (mode !== exp_mode[p]) begin failures++; $display("FAIL fwd_mode_%0d: got %0d want %0d", p, mode, exp_mode[p]); end
      checks++; if (auto_en !== 1'b0) begin failures++; $display("FAIL fwd_auto_%0d: got %b want 0", p, auto_en); end
      checks++; if (stb_cnt - base != p + 1) begin failures++; $display("FAIL fwd_stb_count_%0d: got %0d want %0d", p, stb_cnt - base, p + 1); end
    end
    checks++; if (mode_tog !== 1'b0) begin failures++; $display("FAIL fwd_tog_end: got %b want 0", mode_tog); end
  endtask

  task automatic test_step_back_bounce;
    int base;
    base = stb_cnt;
    for (int i = 0; i < 10; i++) begin
      key_b = (i % 2 == 0) ? 1'b1 : 1'b0;
      wait_neg(2);
    end
    key_b = 1'b0;
    wait_neg(8);
    checks++; if (stb_cnt != base || mode !== 3'd0) begin failures++; $display("FAIL bounce_reject: got events=%0d mode=%0d want events=0 mode=0", stb_cnt - base, mode); end
    key_b = 1'b1;
    wait_neg(10);
    key_b = 1'b0;
    wait_neg(18);
    checks++; if (stb_cnt - base != 1) begin failures++; $display("FAIL back_events: got %0d want 1", stb_cnt - base); end
    checks++; if (mode !== 3'd3) begin failures++; $display("FAIL back_wrap_mode: got %0d want 3", mode); end
    checks++; if (mode_tog !== 1'b1) begin failures++; $display("FAIL back_tog: got %b want 1", mode_tog); end
    checks++; if (auto_en !== 1'b0) begin failures++; $display("FAIL back_auto: got %b want 0", auto_en); end
  endtask

  task automatic test_combo;
    int base;
    base = stb_cnt;
    key_a = 1'b1;
    key_b = 1'b1;
    wait_neg(38);
    checks++; if (auto_en !== 1'b0 || stb_cnt != base) begin failures++; $display("FAIL combo_early: got auto=%b events=%0d want auto=0 events=0", auto_en, stb_cnt - base); end
    wait_neg(1);
    checks++; if (auto_en !== 1'b1) begin failures++; $display("FAIL combo_auto_toggle: got %b want 1", auto_en); end
    checks++; if (mode_stb !== 1'b1) begin failures++; $display("FAIL combo_stb: got %b want 1", mode_stb); end
    checks++; if (mode !== 3'd3) begin failures++; $display("FAIL combo_mode_kept: got %0d want 3", mode); end
    wait_neg(1);
    key_a = 1'b0;
    key_b = 1'b0;
    wait_neg(20);
    checks++; if (stb_cnt - base != 1) begin failures++; $display("FAIL combo_events: got %0d want 1", stb_cnt - base); end
    checks++; if (mode_tog !== 1'b0 || auto_en !== 1'b1 || mode !== 3'd3) begin failures++; $display("FAIL combo_after_release: got tog=%b auto=%b mode=%0d want tog=0 auto=1 mode=3", mode_tog, auto_en, mode); end
    checks++; if (leds !== LEDS_M3A) begin failures++; $display("FAIL combo_leds: got %b want %b", leds, LEDS_M3A); end
  endtask

  task automatic test_aborted_combo;
    int base;
    base = stb_cnt;
    key_a = 1'b1;
    wait_neg(10);
    key_b = 1'b1;
    wait_neg(8);
    key_a = 1'b0;
    key_b = 1'b0;
    wait_neg(20);
    checks++; if (stb_cnt != base) begin failures++; $display("FAIL abort_events: got %0d want 0", stb_cnt - base); end
    checks++; if (mode_tog !== 1'b0) begin failures++; $display("FAIL abort_tog: got %b want 0", mode_tog); end
    checks++; if (mode !== 3'd3 || auto_en !== 1'b1) begin failures++; $display("FAIL abort_state: got mode=%0d auto=%b want mode=3 auto=1", mode, auto_en); end
  endtask

  task automatic test_reset_mid_press;
    int base;
    base = stb_cnt;
    key_a = 1'b1;
    wait_neg(10);
    hdmi4_rst_n = 1'b0;
    #1;
    checks++; if (mode !== 3'd0 || auto_en !== 1'b1 || mode_tog !== 1'b0) begin failures++; $display("FAIL midrst_async: got mode=%0d auto=%b tog=%b want mode=0 auto=1 tog=0", mode, auto_en, mode_tog); end
    wait_neg(3);
    checks++; if (leds !== LEDS_RST) begin failures++; $display("FAIL midrst_leds: got %b want %b", leds, LEDS_RST); end
    hdmi4_rst_n = 1'b1;
    wait_neg(10);
    checks++; if (mode !== 3'd0 || stb_cnt != base) begin failures++; $display("FAIL midrst_held: got mode=%0d events=%0d want mode=0 events=0", mode, stb_cnt - base); end
    key_a = 1'b0;
    wait_neg(18);
    checks++; if (mode !== 3'd1) begin failures++; $display("FAIL midrst_mode: got %0d want 1", mode); end
    checks++; if (auto_en !== 1'b0) begin failures++; $display("FAIL midrst_auto: got %b want 0", auto_en); end
    checks++; if (mode_tog !== 1'b1 || stb_cnt - base != 1) begin failures++; $display("FAIL midrst_event: got tog=%b events=%0d want tog=1 events=1", mode_tog, stb_cnt - base); end
  endtask

  initial begin
    test_reset;
    test_step_fwd;
    test_step_back_bounce;
    test_combo;
    test_aborted_combo;
    test_reset_mid_press;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
